// File: rtl/mor1kx_pcu_event_gen_pkg.sv
// Shared types and limits for the PCU event conditioning block.
// Holds the run-counter type, stall threshold range and event bundle.
package mor1kx_pcu_event_gen_pkg;

    localparam int RUN_W        = 4;
    localparam int STALL_MIN_LO = 1;
    localparam int STALL_MIN_HI = 15;

    typedef logic [RUN_W-1:0] run_t;

    // Registered event strobes, in counters-unit order.
    typedef struct packed {
        logic load;
        logic store;
        logic ifetch;
        logic dcache_miss;
        logic icache_miss;
        logic dtlb_miss;
        logic itlb_miss;
        logic ifetch_stall;
        logic lsu_stall;
        logic brn_stall;
        logic datadep_stall;
    } pcu_events_t;

    function automatic bit stall_min_legal(input int v);
        return (v >= STALL_MIN_LO) && (v <= STALL_MIN_HI);
    endfunction

endpackage

// File: rtl/mor1kx_pcu_stall_filter.sv
// Run-length filter for one stall cause.
// Ports: clk, rst (sync, active-high), enable_i, stall_i -> event_o (comb).
module mor1kx_pcu_stall_filter
    import mor1kx_pcu_event_gen_pkg::*;
#(
    parameter int OPTION_STALL_MIN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic stall_i,
    output logic event_o
);

    run_t run_q;
    run_t run_d;

    // Counter saturates at the threshold, so long runs never wrap.
    always_comb begin
        run_d = run_q;
        if (!enable_i || !stall_i) begin
            run_d = '0;
        end else if (int'(run_q) < OPTION_STALL_MIN) begin
            run_d = run_q + run_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Compare uses the pre-increment count: cycle N of a run fires.
    assign event_o = enable_i & stall_i &
                     (int'(run_q) >= OPTION_STALL_MIN - 1);

endmodule

// File: rtl/mor1kx_pcu_event_gen.sv
// Turns pipeline/cache/MMU status into one-cycle PCU event strobes.
// Inputs: retire/fetch/flush qualifiers, refill/reload levels, stall
// levels, enable. Outputs: 11 registered pcu_event_*_o strobes.
module mor1kx_pcu_event_gen
    import mor1kx_pcu_event_gen_pkg::*;
#(
    parameter int OPTION_STALL_MIN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic exec_valid_i,
    input  logic exec_op_load_i,
    input  logic exec_op_store_i,
    input  logic pipeline_flush_i,
    input  logic fetch_valid_i,
    input  logic dc_refill_i,
    input  logic ic_refill_i,
    input  logic dtlb_reload_i,
    input  logic itlb_reload_i,
    input  logic fetch_stall_i,
    input  logic lsu_stall_i,
    input  logic brn_stall_i,
    input  logic datadep_stall_i,
    output logic pcu_event_load_o,
    output logic pcu_event_store_o,
    output logic pcu_event_ifetch_o,
    output logic pcu_event_dcache_miss_o,
    output logic pcu_event_icache_miss_o,
    output logic pcu_event_dtlb_miss_o,
    output logic pcu_event_itlb_miss_o,
    output logic pcu_event_ifetch_stall_o,
    output logic pcu_event_lsu_stall_o,
    output logic pcu_event_brn_stall_o,
    output logic pcu_event_datadep_stall_o
);

    if (!stall_min_legal(OPTION_STALL_MIN)) begin : g_bad_stall_min
        $error("OPTION_STALL_MIN must be in 1..15");
    end

    logic [3:0]  lvl;
    logic [3:0]  hist_q;
    logic [3:0]  miss;
    logic [3:0]  stl_in;
    logic [3:0]  stl_ev;
    pcu_events_t ev_d;
    pcu_events_t ev_q;

    assign lvl    = {dc_refill_i, ic_refill_i, dtlb_reload_i, itlb_reload_i};
    assign stl_in = {fetch_stall_i, lsu_stall_i, brn_stall_i, datadep_stall_i};

    // History resets high so a refill spanning reset is not counted, and
    // keeps tracking while disabled so re-enabling mid-refill is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= lvl;
        end
    end

    assign miss = {4{enable_i}} & lvl & ~hist_q;

    for (genvar g = 0; g < 4; g++) begin : g_stall
        mor1kx_pcu_stall_filter #(
            .OPTION_STALL_MIN(OPTION_STALL_MIN)
        ) u_filt (
            .clk     (clk),
            .rst     (rst),
            .enable_i(enable_i),
            .stall_i (stl_in[g]),
            .event_o (stl_ev[g])
        );
    end

    logic retire_ok;
    assign retire_ok = enable_i & exec_valid_i & ~pipeline_flush_i;

    always_comb begin
        ev_d               = '0;
        ev_d.load          = retire_ok & exec_op_load_i;
        ev_d.store         = retire_ok & exec_op_store_i;
        ev_d.ifetch        = enable_i & fetch_valid_i & ~pipeline_flush_i;
        ev_d.dcache_miss   = miss[3];
        ev_d.icache_miss   = miss[2];
        ev_d.dtlb_miss     = miss[1];
        ev_d.itlb_miss     = miss[0];
        ev_d.ifetch_stall  = stl_ev[3];
        ev_d.lsu_stall     = stl_ev[2];
        ev_d.brn_stall     = stl_ev[1];
        ev_d.datadep_stall = stl_ev[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    assign pcu_event_load_o          = ev_q.load;
    assign pcu_event_store_o         = ev_q.store;
    assign pcu_event_ifetch_o        = ev_q.ifetch;
    assign pcu_event_dcache_miss_o   = ev_q.dcache_miss;
    assign pcu_event_icache_miss_o   = ev_q.icache_miss;
    assign pcu_event_dtlb_miss_o     = ev_q.dtlb_miss;
    assign pcu_event_itlb_miss_o     = ev_q.itlb_miss;
    assign pcu_event_ifetch_stall_o  = ev_q.ifetch_stall;
    assign pcu_event_lsu_stall_o     = ev_q.lsu_stall;
    assign pcu_event_brn_stall_o     = ev_q.brn_stall;
    assign pcu_event_datadep_stall_o = ev_q.datadep_stall;

endmodule

// File: tb/tb_mor1kx_pcu_event_gen.sv
// Directed bench for mor1kx_pcu_event_gen with thresholds 1, 2 and 3.
// Three instances share inputs; each has its own output vector.
module tb_mor1kx_pcu_event_gen;

    // Input vector bit masks.
    localparam logic [13:0] EN  = 14'h2000;
    localparam logic [13:0] V   = 14'h1000;
    localparam logic [13:0] LD  = 14'h0800;
    localparam logic [13:0] ST  = 14'h0400;
    localparam logic [13:0] FL  = 14'h0200;
    localparam logic [13:0] FV  = 14'h0100;
    localparam logic [13:0] DC  = 14'h0080;
    localparam logic [13:0] IC  = 14'h0040;
    localparam logic [13:0] DT  = 14'h0020;
    localparam logic [13:0] IT  = 14'h0010;
    localparam logic [13:0] FS  = 14'h0008;
    localparam logic [13:0] LS  = 14'h0004;
    localparam logic [13:0] BS  = 14'h0002;
    localparam logic [13:0] DS  = 14'h0001;
    localparam logic [13:0] LVL = DC | IC | DT | IT;
    localparam logic [13:0] STL = FS | LS | BS | DS;

    // Output vector bit masks.
    localparam logic [10:0] O_LD  = 11'h400;
    localparam logic [10:0] O_ST  = 11'h200;
    localparam logic [10:0] O_IF  = 11'h100;
    localparam logic [10:0] O_DCM = 11'h080;
    localparam logic [10:0] O_ICM = 11'h040;
    localparam logic [10:0] O_ITM = 11'h010;
    localparam logic [10:0] O_STL = 11'h00F;
    localparam logic [10:0] O_LSU = 11'h004;
    localparam logic [10:0] O_BRN = 11'h002;
    localparam logic [10:0] O_DDS = 11'h001;
    localparam logic [10:0] O_FS  = 11'h008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] vin = '0;
    wire  [10:0] o [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mor1kx_pcu_event_gen #(
            .OPTION_STALL_MIN(k + 1)
        ) dut (
            .clk                      (clk),
            .rst                      (rst),
            .enable_i                 (vin[13]),
            .exec_valid_i             (vin[12]),
            .exec_op_load_i           (vin[11]),
            .exec_op_store_i          (vin[10]),
            .pipeline_flush_i         (vin[9]),
            .fetch_valid_i            (vin[8]),
            .dc_refill_i              (vin[7]),
            .ic_refill_i              (vin[6]),
            .dtlb_reload_i            (vin[5]),
            .itlb_reload_i            (vin[4]),
            .fetch_stall_i            (vin[3]),
            .lsu_stall_i              (vin[2]),
            .brn_stall_i              (vin[1]),
            .datadep_stall_i          (vin[0]),
            .pcu_event_load_o         (o[k][10]),
            .pcu_event_store_o        (o[k][9]),
            .pcu_event_ifetch_o       (o[k][8]),
            .pcu_event_dcache_miss_o  (o[k][7]),
            .pcu_event_icache_miss_o  (o[k][6]),
            .pcu_event_dtlb_miss_o    (o[k][5]),
            .pcu_event_itlb_miss_o    (o[k][4]),
            .pcu_event_ifetch_stall_o (o[k][3]),
            .pcu_event_lsu_stall_o    (o[k][2]),
            .pcu_event_brn_stall_o    (o[k][1]),
            .pcu_event_datadep_stall_o(o[k][0])
        );
    end

    typedef struct {
        string       name;
        logic [13:0] in;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [10:0] act,
                       input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [13:0] i,
                       input logic [10:0] e);
        vec_t v;
        v.name = nm;
        v.in   = i;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    logic [10:0] ex3 [7];
    logic [10:0] ex2 [7];
    logic [10:0] exb [5];
    logic [4:0]  brn_pat;

    initial begin
        add("load",         EN|V|LD,          O_LD);
        add("load_flush",   EN|V|LD|FL,       '0);
        add("store",        EN|V|ST,          O_ST);
        add("load_store",   EN|V|LD|ST,       O_LD|O_ST);
        add("ifetch",       EN|FV,            O_IF);
        add("ifetch_flush", EN|FV|FL,         '0);
        add("load_novalid", EN|LD,            '0);
        add("all_on",       EN|V|LD|ST|FV|LVL|STL, 11'h7FF);
        add("all_hold",     EN|V|LD|ST|FV|LVL|STL, O_LD|O_ST|O_IF|O_STL);
        add("all_flush",    EN|V|LD|ST|FV|FL|LVL|STL, O_STL);
        add("idle0",        EN,               '0);
        add("dc_flush",     EN|FL|DC,         O_DCM);
        add("idle1",        EN,               '0);
        add("disabled",     V|LD|FV|DC|STL,   '0);
        add("itlb_dis",     IT,               '0);
        add("itlb_reen",    EN|IT,            '0);
        add("itlb_drop",    EN,               '0);
        add("itlb_rerise",  EN|IT,            O_ITM);
        add("dis_idle",     '0,               '0);
        add("en_rise_same", EN|V|LD|IC,       O_LD|O_ICM);
        add("idle2",        EN,               '0);

        // Reset with a refill in flight across it.
        rst = 1'b1;
        vin = EN | DC;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) chk($sformatf("reset_out%0d", k), o[k], '0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("rst_refill_hold%0d", c), o[0], '0);
        end
        vin = EN;
        cyc();
        chk("rst_refill_drop", o[0], '0);
        vin = EN | DC;
        cyc();
        chk("rst_refill_rerise", o[0], O_DCM);
        cyc();
        chk("rst_refill_pulse_end", o[0], '0);
        vin = EN;
        cyc();

        foreach (tbl[i]) begin
            vin = tbl[i].in;
            cyc();
            chk(tbl[i].name, o[0], tbl[i].exp);
        end

        // Five-cycle lsu stall: thresholds 3 and 2.
        ex3 = '{'0, '0, O_LSU, O_LSU, O_LSU, '0, '0};
        ex2 = '{'0, O_LSU, O_LSU, O_LSU, O_LSU, '0, '0};
        for (int c = 0; c < 7; c++) begin
            vin = (c < 5) ? (EN | LS) : EN;
            cyc();
            chk($sformatf("lsu_thr3_c%0d", c), o[2], ex3[c]);
            chk($sformatf("lsu_thr2_c%0d", c), o[1], ex2[c]);
        end

        // Broken run 1,1,0,1,0 with threshold 2.
        brn_pat = 5'b01011;
        exb = '{'0, O_BRN, '0, '0, '0};
        for (int c = 0; c < 5; c++) begin
            vin = brn_pat[c] ? (EN | BS) : EN;
            cyc();
            chk($sformatf("brn_break_c%0d", c), o[1], exb[c]);
        end

        // Twenty-cycle run: saturates without wrapping.
        for (int c = 0; c < 20; c++) begin
            vin = EN | DS;
            cyc();
            chk($sformatf("dds_sat_c%0d", c), o[2], (c < 2) ? '0 : O_DDS);
        end
        vin = EN;
        cyc();
        chk("dds_sat_end", o[2], '0);

        // Reset mid-stall restarts the run.
        for (int c = 0; c < 4; c++) begin
            vin = EN | FS;
            cyc();
            chk($sformatf("fs_pre_c%0d", c), o[2], (c < 2) ? '0 : O_FS);
        end
        rst = 1'b1;
        cyc();
        chk("fs_in_reset", o[2], '0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("fs_post_c%0d", c), o[2], (c < 2) ? '0 : O_FS);
        end
        vin = EN;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mor1kx_pcu_event_gen.md
# mor1kx_pcu_event_gen

Conditions raw pipeline, cache and MMU status signals into the single-cycle event strobes consumed by the performance counters unit (`pcu_event_*_i`). It sits between the core pipeline/cache/MMU and the counters. It converts multi-cycle miss/refill levels into one pulse per miss and qualifies retirement with flush. It filters short stalls through a programmable run-length threshold. All outputs are registered, so the counters unit sees a fixed one-cycle latency and a clean timing boundary.

## Interface
- `OPTION_STALL_MIN`, default 1: consecutive stall cycles required before a stall event asserts; legal range 1..15.
- `clk` in 1: core clock.
- `rst` in 1: reset; synchronous, active-high.
- `enable_i` in 1: event generation enable.
- `exec_valid_i` in 1: one instruction retires this cycle.
- `exec_op_load_i` in 1: retiring instruction is a load.
- `exec_op_store_i` in 1: retiring instruction is a store.
- `pipeline_flush_i` in 1: pipeline flush this cycle.
- `fetch_valid_i` in 1: fetch delivers an instruction this cycle.
- `dc_refill_i`, `ic_refill_i` in 1 each: cache refill in progress (level).
- `dtlb_reload_i`, `itlb_reload_i` in 1 each: TLB reload in progress (level).
- `fetch_stall_i`, `lsu_stall_i`, `brn_stall_i`, `datadep_stall_i` in 1 each: stall causes (level).
- `pcu_event_load_o`, `pcu_event_store_o`, `pcu_event_ifetch_o` out 1 each: access events.
- `pcu_event_dcache_miss_o`, `pcu_event_icache_miss_o`, `pcu_event_dtlb_miss_o`, `pcu_event_itlb_miss_o` out 1 each: miss events.
- `pcu_event_ifetch_stall_o`, `pcu_event_lsu_stall_o`, `pcu_event_brn_stall_o`, `pcu_event_datadep_stall_o` out 1 each: stall events.

## Operation
- **Load/store:** the event fires when `exec_valid_i & exec_op_load_i & ~pipeline_flush_i`, and likewise for store with `exec_op_store_i`. If load and store are both high, both events fire.
- **Ifetch:** the event fires when `fetch_valid_i & ~pipeline_flush_i`.
- **Misses:**
  - A miss is a rising edge of its level input: `level & ~level_q`, with one history flop per source.
  - A continuous high level produces exactly one pulse.
  - A level that drops for one cycle and rises again produces a second pulse.
- **Stalls:**
  - Each stall source has a 4-bit run counter `run`. It clears when the level is low and increments while the level is high, saturating at `OPTION_STALL_MIN`.
  - The event fires in a stall cycle when `run >= OPTION_STALL_MIN-1`, using the value before increment.
  - So the Nth and every later consecutive stall cycle count, with N = `OPTION_STALL_MIN`. N=1 means every stall cycle counts.
- **Enable:**
  - While `enable_i=0`, all event outputs are 0 and the run counters are held at 0.
  - Miss history flops keep tracking while disabled, so re-enabling during a refill causes no spurious miss.
- **Flush:** flush affects only load, store and ifetch. Miss edges and stall runs are unaffected.

## Timing
- Every output is a flop: an event is visible exactly 1 cycle after the qualifying input cycle.
- Reset values:
  - All outputs 0.
  - Run counters 0.
  - Miss history flops 1, so a refill or reload in flight across reset is not counted.
- Reset mid-stall: the counter restarts from 0 after `rst` falls, and the threshold must be met again.
- Reset mid-refill: no pulse until the level drops and rises again.
- An input change in the same cycle as `enable_i` rising is evaluated with enable=1.
- Counter saturation: no wrap. A run longer than 15 cycles keeps the event asserted every cycle.

## Structure
- PCMR event bit indices (`OR1K_PCMR_LA`..`OR1K_PCMR_DDS`) already exist in `mor1kx-defines.v`. No new shared constants are needed beyond a range check on `OPTION_STALL_MIN`.
- Sub-module `mor1kx_pcu_stall_filter` contains the run counter, threshold compare and enable clear. It has parameter `OPTION_STALL_MIN`, inputs `clk`, `rst`, `enable_i`, `stall_i`, and output `event_o` (combinational). It is instantiated four times.
- The top level holds the edge-detect flops, the load/store/ifetch qualification and the output register bank.

## Test plan
- Reset: `dc_refill_i=1` through reset, held 5 cycles after `rst` falls, then dropped and raised again → `pcu_event_dcache_miss_o` stays 0 until the cycle after the re-rise, then a single 1-cycle pulse.
- Load under flush:
  - `exec_valid_i=1`, `exec_op_load_i=1`, flush=0 → `pcu_event_load_o=1` next cycle.
  - Same stimulus with `pipeline_flush_i=1` → 0.
- Stall threshold: `OPTION_STALL_MIN=3`, `lsu_stall_i` high 5 cycles → `pcu_event_lsu_stall_o` high for exactly 3 cycles, starting 3 cycles after the stall starts.
- Stall break: `OPTION_STALL_MIN=2`, stall pattern 1,1,0,1,0 → a single event pulse from the first run only.
- Enable re-arm: `itlb_reload_i` rises while `enable_i=0`, then enable is raised while the level stays high → no `pcu_event_itlb_miss_o` pulse.
- Simultaneous events: all 13 inputs active in one cycle, with 1-cycle-old history low and `OPTION_STALL_MIN=1` → all 11 outputs high next cycle.
